elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
//  SCAN-style car controller for the 5-floor elevator. Latches hall calls from the switch-decode
//  stage (UP_REQ/DOWN_REQ), holds them as pending, moves the car one floor per MOVE_CYCLES and
//  opens the door for DOOR_CYCLES at each served floor. Outputs drive the floor/direction display.
// PARAMETERS
//  N_FLOORS     5    number of floors, floor 0 = bottom
//  MOVE_CYCLES  50   CLK cycles to travel one floor (>=1)
//  DOOR_CYCLES  100  CLK cycles the door stays open (>=1)
// PORTS
//  CLK        in   1         system clock, rising edge
//  RST_N      in   1         asynchronous, active-low reset
//  UP_REQ     in   N_FLOORS  up hall calls, level, sampled every cycle; bit N_FLOORS-1 ignored
//  DOWN_REQ   in   N_FLOORS  down hall calls, level, sampled every cycle; bit 0 ignored
//  UP_PEND    out  N_FLOORS  latched pending up calls
//  DOWN_PEND  out  N_FLOORS  latched pending down calls
//  FLOOR      out  $clog2(N_FLOORS)  current car floor
//  DIR        out  2         00 none, 01 up, 10 down (11 never driven)
//  DOOR_OPEN  out  1         high for every cycle in DOOR
//  ARRIVED    out  1         1-cycle pulse on entry to DOOR
// BEHAVIOUR
//  Reset (async assert, sync release): state DECIDE, FLOOR=0, DIR=00, pends=0, DOOR_OPEN=0,
//   ARRIVED=0, timer=0. Reset mid-move/mid-door abandons the operation; all calls are lost.
//  Latching: PEND[i] <= PEND[i] | REQ[i] each cycle, except cleared bits below (clear wins).
//   During DOOR, a call at FLOOR in the current DIR is discarded (not latched, timer not extended).
//  "above" = |PEND bits (either dir) at floors > FLOOR; "below" likewise < FLOOR.
//  DECIDE (1 cycle), preference P = DOWN if DIR==10 else UP. For P=UP:
//   1. UP_PEND[FLOOR]          -> DOOR, clear UP_PEND[FLOOR], DIR=01
//   2. else above              -> MOVE_UP, DIR=01
//   3. else DOWN_PEND[FLOOR]   -> DOOR, clear DOWN_PEND[FLOOR], DIR=10
//   4. else below              -> MOVE_DOWN, DIR=10
//   5. else stay DECIDE, DIR=00
//   P=DOWN is the mirror (DOWN_PEND/below first, then UP_PEND/above).
//  MOVE_UP/MOVE_DOWN: timer counts 0..MOVE_CYCLES-1; on terminal count FLOOR +/-1, timer=0,
//   -> DECIDE. One floor = MOVE_CYCLES+1 cycles. FLOOR never leaves 0..N_FLOORS-1 (DECIDE only
//   moves toward a pending floor, so no wrap).
//  DOOR: ARRIVED=1 first cycle; DOOR_OPEN=1 for exactly DOOR_CYCLES cycles, then -> DECIDE.
//  Simultaneous UP and DOWN call at the car's floor while idle: up served first (door), down
//   served on the next DECIDE as a second door cycle with DIR=10 unless calls above exist.
//  Requests arriving during MOVE take effect at the next DECIDE (the floor just reached).
// STRUCTURE
//  Package elevator_pkg: DIR_NONE/DIR_UP/DIR_DOWN codes; state enum {DECIDE,MOVE_UP,MOVE_DOWN,
//   DOOR}; default N_FLOORS.
//  Sub-module elev_timer: load/clear + terminal-count counter, width $clog2(max(MOVE,DOOR)+1),
//   shared by MOVE and DOOR states (one instance).
//  Top: pending registers, above/below reduction, FSM, FLOOR/DIR registers.
// TESTING (MOVE_CYCLES=4, DOOR_CYCLES=3)
//  1 Reset: hold RST_N=0 with REQ toggling -> all outputs 0; release -> DECIDE, DIR=00, no motion.
//  2 Idle at 0, UP_REQ[3] 1-cycle pulse -> UP_PEND=01000, DIR=01, FLOOR steps 1,2,3 at 5-cycle
//    spacing, ARRIVED 1 cycle, DOOR_OPEN 3 cycles, UP_PEND=0, then DIR=00.
//  3 Car at 2 moving up to 4, DOWN_REQ[1] and UP_REQ[3] arrive -> stops at 3 (up), then 4, then
//    reverses DIR=10 and stops at 1; DOWN_REQ[1] never served before floor 4.
//  4 Car idle at 2, UP_REQ[2] and DOWN_REQ[2] same cycle -> two door cycles at 2: first DIR=01
//    clears UP_PEND[2], second DIR=10 clears DOWN_PEND[2]; FLOOR stays 2.
//  5 Door open at 1 with DIR=01, UP_REQ[1] held high throughout -> not latched, door still 3
//    cycles; UP_REQ[4] ignored on both top/bottom invalid bits (DOWN_REQ[0] too).
//  6 Assert RST_N=0 mid-MOVE_UP between floors 1 and 2 -> FLOOR=0, pends=0 immediately
//    (async); after release no motion without new calls.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared codes and types for the SCAN elevator car controller.
package elevator_pkg;

    localparam int DEFAULT_N_FLOORS = 5;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        DECIDE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Up-counter shared by travel and door phases: cleared while deciding,
// wraps to zero on reaching the terminal value.
module elev_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q, count_d;

    assign tc_o    = !clr_i && (count_q == term_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q + W'(1);
        if (clr_i || tc_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN car controller: latches hall calls, steps one floor per travel period
// and holds the door open at each served floor.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = DEFAULT_N_FLOORS,
    parameter int MOVE_CYCLES = 50,
    parameter int DOOR_CYCLES = 100
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_FLOORS-1:0]         up_req_i,
    input  logic [N_FLOORS-1:0]         down_req_i,
    output logic [N_FLOORS-1:0]         up_pend_o,
    output logic [N_FLOORS-1:0]         down_pend_o,
    output logic [$clog2(N_FLOORS)-1:0] floor_o,
    output logic [1:0]                  dir_o,
    output logic                        door_open_o,
    output logic                        arrived_o
);

    localparam int FW = $clog2(N_FLOORS);
    localparam int TW = $clog2(max_int(MOVE_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [N_FLOORS-1:0] UP_OK   = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DOWN_OK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    state_e               state_q, state_d;
    dir_e                 dir_q, dir_d;
    logic [FW-1:0]        floor_q, floor_d;
    logic [N_FLOORS-1:0]  up_pend_q, up_pend_d, down_pend_q, down_pend_d;
    logic [N_FLOORS-1:0]  at_floor, above_mask, below_mask, any_pend;
    logic [N_FLOORS-1:0]  up_in, down_in, up_clr, down_clr;
    logic                 above, below, tmr_tc;
    logic [TW-1:0]        tmr_count, tmr_term;

    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_floor_mask
        assign at_floor[gi]   = (floor_q == FW'(gi));
        assign above_mask[gi] = (FW'(gi) > floor_q);
        assign below_mask[gi] = (FW'(gi) < floor_q);
    end

    assign any_pend = up_pend_q | down_pend_q;
    assign above    = |(any_pend & above_mask);
    assign below    = |(any_pend & below_mask);

    // While the door is open, a call at this floor in the travel direction is already being served.
    assign up_in   = up_req_i & UP_OK &
                     ~((state_q == DOOR && dir_q == DIR_UP) ? at_floor : '0);
    assign down_in = down_req_i & DOWN_OK &
                     ~((state_q == DOOR && dir_q == DIR_DOWN) ? at_floor : '0);

    assign up_pend_d   = (up_pend_q | up_in) & ~up_clr;
    assign down_pend_d = (down_pend_q | down_in) & ~down_clr;

    assign tmr_term = (state_q == DOOR) ? TW'(DOOR_CYCLES - 1) : TW'(MOVE_CYCLES - 1);

    elev_timer #(.W(TW)) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (state_q == DECIDE),
        .term_i  (tmr_term),
        .count_o (tmr_count),
        .tc_o    (tmr_tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= DECIDE;
            dir_q       <= DIR_NONE;
            floor_q     <= '0;
            up_pend_q   <= '0;
            down_pend_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            floor_q     <= floor_d;
            up_pend_q   <= up_pend_d;
            down_pend_q <= down_pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        floor_d  = floor_q;
        up_clr   = '0;
        down_clr = '0;
        case (state_q)
            DECIDE: begin
                if (dir_q != DIR_DOWN) begin
                    if (|(up_pend_q & at_floor)) begin
                        state_d = DOOR;      up_clr = at_floor;   dir_d = DIR_UP;
                    end else if (above) begin
                        state_d = MOVE_UP;   dir_d = DIR_UP;
                    end else if (|(down_pend_q & at_floor)) begin
                        state_d = DOOR;      down_clr = at_floor; dir_d = DIR_DOWN;
                    end else if (below) begin
                        state_d = MOVE_DOWN; dir_d = DIR_DOWN;
                    end else begin
                        dir_d = DIR_NONE;
                    end
                end else begin
                    if (|(down_pend_q & at_floor)) begin
                        state_d = DOOR;      down_clr = at_floor; dir_d = DIR_DOWN;
                    end else if (below) begin
                        state_d = MOVE_DOWN; dir_d = DIR_DOWN;
                    end else if (|(up_pend_q & at_floor)) begin
                        state_d = DOOR;      up_clr = at_floor;   dir_d = DIR_UP;
                    end else if (above) begin
                        state_d = MOVE_UP;   dir_d = DIR_UP;
                    end else begin
                        dir_d = DIR_NONE;
                    end
                end
            end
            MOVE_UP: if (tmr_tc) begin
                floor_d = floor_q + FW'(1);
                state_d = DECIDE;
            end
            MOVE_DOWN: if (tmr_tc) begin
                floor_d = floor_q - FW'(1);
                state_d = DECIDE;
            end
            DOOR: if (tmr_tc) begin
                state_d = DECIDE;
            end
            default: state_d = DECIDE;
        endcase
    end

    always_comb begin
        door_open_o = (state_q == DOOR);
        arrived_o   = (state_q == DOOR) && (tmr_count == '0);
        dir_o       = dir_q;
        floor_o     = floor_q;
        up_pend_o   = up_pend_q;
        down_pend_o = down_pend_q;
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for the elevator controller with short travel and door periods.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] up_req = '0;
    logic [4:0] down_req = '0;
    logic [4:0] up_pend, down_pend;
    logic [2:0] floor;
    logic [1:0] dir;
    logic       door_open, arrived;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elevator_scheduler #(
        .N_FLOORS    (5),
        .MOVE_CYCLES (4),
        .DOOR_CYCLES (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .up_req_i    (up_req),
        .down_req_i  (down_req),
        .up_pend_o   (up_pend),
        .down_pend_o (down_pend),
        .floor_o     (floor),
        .dir_o       (dir),
        .door_open_o (door_open),
        .arrived_o   (arrived)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        // 1: reset holds everything at zero despite toggling calls
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_req   = (i % 2 == 0) ? 5'b01111 : 5'b01010;
            down_req = (i % 2 == 0) ? 5'b11110 : 5'b10100;
            step(1);
            check("t1_rst_up_pend", int'(up_pend), 0);
            check("t1_rst_down_pend", int'(down_pend), 0);
        end
        check("t1_rst_floor", int'(floor), 0);
        check("t1_rst_dir", int'(dir), 0);
        check("t1_rst_door", int'(door_open), 0);
        check("t1_rst_arrived", int'(arrived), 0);
        up_req = '0; down_req = '0;
        rst_n = 1'b1;
        step(5);
        check("t1_idle_floor", int'(floor), 0);
        check("t1_idle_dir", int'(dir), 0);
        check("t1_idle_door", int'(door_open), 0);

        // 2: single up call to floor 3
        up_req = 5'b01000; step(1); up_req = '0;
        check("t2_up_pend", int'(up_pend), 8);
        check("t2_dir_pre", int'(dir), 0);
        step(1);
        check("t2_dir_up", int'(dir), 1);
        check("t2_floor0", int'(floor), 0);
        step(4); check("t2_floor1", int'(floor), 1);
        step(5); check("t2_floor2", int'(floor), 2);
        step(5); check("t2_floor3", int'(floor), 3);
        check("t2_door_pre", int'(door_open), 0);
        step(1);
        check("t2_arrived", int'(arrived), 1);
        check("t2_door1", int'(door_open), 1);
        check("t2_up_clr", int'(up_pend), 0);
        step(1);
        check("t2_arrived_pulse", int'(arrived), 0);
        check("t2_door2", int'(door_open), 1);
        step(1); check("t2_door3", int'(door_open), 1);
        step(1); check("t2_door_closed", int'(door_open), 0);
        step(1);
        check("t2_dir_none", int'(dir), 0);
        check("t2_floor_hold", int'(floor), 3);

        // 3: calls arriving during an upward sweep
        do_reset();
        down_req = 5'b10000; step(1); down_req = '0;
        check("t3_down_pend4", int'(down_pend), 16);
        step(11);
        check("t3_floor2", int'(floor), 2);
        check("t3_dir_up", int'(dir), 1);
        down_req = 5'b00010; up_req = 5'b01000; step(1);
        down_req = '0; up_req = '0;
        check("t3_down_pend", int'(down_pend), 18);
        check("t3_up_pend", int'(up_pend), 8);
        step(3); check("t3_floor3", int'(floor), 3);
        step(1);
        check("t3_arr3", int'(arrived), 1);
        check("t3_dir3", int'(dir), 1);
        check("t3_up_clr", int'(up_pend), 0);
        step(3); check("t3_door3_closed", int'(door_open), 0);
        step(5);
        check("t3_floor4", int'(floor), 4);
        check("t3_down1_kept", int'(down_pend), 18);
        step(1);
        check("t3_arr4", int'(arrived), 1);
        check("t3_dir_rev", int'(dir), 2);
        check("t3_down_pend_after4", int'(down_pend), 2);
        step(4);
        check("t3_moving_down", int'(door_open), 0);
        check("t3_dir_down", int'(dir), 2);
        step(4); check("t3_floor3_down", int'(floor), 3);
        step(5); check("t3_floor2_down", int'(floor), 2);
        step(5);
        check("t3_floor1", int'(floor), 1);
        check("t3_arr_pre1", int'(arrived), 0);
        step(1);
        check("t3_arr1", int'(arrived), 1);
        check("t3_dir1", int'(dir), 2);
        check("t3_down_clr", int'(down_pend), 0);
        step(4);
        check("t3_dir_none", int'(dir), 0);
        check("t3_floor_end", int'(floor), 1);

        // 4: simultaneous up and down call at the idle car's floor
        up_req = 5'b00100; step(1); up_req = '0;
        step(1); check("t4_setup_dir", int'(dir), 1);
        step(4); check("t4_setup_floor", int'(floor), 2);
        step(1); check("t4_setup_arr", int'(arrived), 1);
        step(3); step(1); check("t4_setup_idle", int'(dir), 0);
        up_req = 5'b00100; down_req = 5'b00100; step(1);
        up_req = '0; down_req = '0;
        check("t4_up_pend", int'(up_pend), 4);
        check("t4_down_pend", int'(down_pend), 4);
        step(1);
        check("t4_arr_a", int'(arrived), 1);
        check("t4_dir_a", int'(dir), 1);
        check("t4_up_clr", int'(up_pend), 0);
        check("t4_down_held", int'(down_pend), 4);
        step(3); check("t4_door_a_closed", int'(door_open), 0);
        step(1);
        check("t4_arr_b", int'(arrived), 1);
        check("t4_dir_b", int'(dir), 2);
        check("t4_down_clr", int'(down_pend), 0);
        check("t4_floor", int'(floor), 2);
        step(3); step(1);
        check("t4_dir_none", int'(dir), 0);
        check("t4_floor_end", int'(floor), 2);

        // 5: same-direction call during door is discarded; invalid end bits ignored
        up_req = 5'b00010; step(1); up_req = '0;
        step(1); check("t5_dir_down", int'(dir), 2);
        step(4); check("t5_floor1", int'(floor), 1);
        step(1);
        check("t5_arr", int'(arrived), 1);
        check("t5_dir_up", int'(dir), 1);
        check("t5_up_clr", int'(up_pend), 0);
        up_req = 5'b10010; down_req = 5'b00001;
        step(1);
        check("t5_up_masked_a", int'(up_pend), 0);
        check("t5_down_masked", int'(down_pend), 0);
        check("t5_door2", int'(door_open), 1);
        step(1);
        check("t5_door3", int'(door_open), 1);
        check("t5_up_masked_b", int'(up_pend), 0);
        step(1);
        check("t5_door_closed", int'(door_open), 0);
        check("t5_up_masked_c", int'(up_pend), 0);
        check("t5_down_masked_c", int'(down_pend), 0);
        up_req = '0; down_req = '0;
        step(1);
        check("t5_dir_none", int'(dir), 0);
        check("t5_floor_end", int'(floor), 1);

        // 6: asynchronous reset in the middle of a move
        up_req = 5'b00100; step(1); up_req = '0;
        step(2);
        check("t6_mid_floor", int'(floor), 1);
        check("t6_mid_dir", int'(dir), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_floor", int'(floor), 0);
        check("t6_async_up_pend", int'(up_pend), 0);
        check("t6_async_dir", int'(dir), 0);
        @(negedge clk);
        step(2);
        rst_n = 1'b1;
        step(10);
        check("t6_after_floor", int'(floor), 0);
        check("t6_after_dir", int'(dir), 0);
        check("t6_after_door", int'(door_open), 0);
        check("t6_after_pend", int'(up_pend | down_pend), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
